// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: owns the PC, selects sequential or redirect next-PC,
// and registers the fetched word into IF/ID with stall, flush and fault tagging.
module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] IMEM_BASE    = 32'hBFC00000,
  parameter logic [31:0] IMEM_SIZE    = 32'h00001000,
  parameter logic [31:0] NOP_INSTR    = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        FetchFaultD,
  output logic [31:0] FetchCount
);

  localparam logic [31:0] IMEM_LAST = IMEM_BASE + IMEM_SIZE - 32'd4;

  logic [31:0] pcf_q, pcf_d;
  logic [31:0] instr_dec_q, instr_dec_d;
  logic [31:0] pc_dec_q, pc_dec_d;
  logic [31:0] pc_plus4_dec_q, pc_plus4_dec_d;
  logic        valid_dec_q, valid_dec_d;
  logic        fault_dec_q, fault_dec_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] pc_plus4_f;
  logic        fault_f;

  always_comb begin
    pc_plus4_f = pcf_q + 32'd4;
    fault_f    = (pcf_q[1:0] != 2'b00) || (pcf_q < IMEM_BASE) || (pcf_q > IMEM_LAST);

    // Redirect outranks stall so a taken branch is never dropped.
    if (PCSrcE)      pcf_d = PCTargetE;
    else if (StallF) pcf_d = pcf_q;
    else             pcf_d = pc_plus4_f;
  end

  always_comb begin
    instr_dec_d    = instr_dec_q;
    pc_dec_d       = pc_dec_q;
    pc_plus4_dec_d = pc_plus4_dec_q;
    valid_dec_d    = valid_dec_q;
    fault_dec_d    = fault_dec_q;
    fetch_count_d  = fetch_count_q;

    if (FlushD) begin
      instr_dec_d    = NOP_INSTR;
      pc_dec_d       = pcf_q;
      pc_plus4_dec_d = pc_plus4_f;
      valid_dec_d    = 1'b0;
      fault_dec_d    = 1'b0;
    end else if (!StallD) begin
      // Faulting fetches are captured as tagged bubbles; the trap decision is downstream.
      instr_dec_d    = fault_f ? NOP_INSTR : InstrF;
      pc_dec_d       = pcf_q;
      pc_plus4_dec_d = pc_plus4_f;
      valid_dec_d    = 1'b1;
      fault_dec_d    = fault_f;
      fetch_count_d  = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcf_q          <= RESET_VECTOR;
      instr_dec_q    <= NOP_INSTR;
      pc_dec_q       <= 32'd0;
      pc_plus4_dec_q <= 32'd0;
      valid_dec_q    <= 1'b0;
      fault_dec_q    <= 1'b0;
      fetch_count_q  <= 32'd0;
    end else begin
      pcf_q          <= pcf_d;
      instr_dec_q    <= instr_dec_d;
      pc_dec_q       <= pc_dec_d;
      pc_plus4_dec_q <= pc_plus4_dec_d;
      valid_dec_q    <= valid_dec_d;
      fault_dec_q    <= fault_dec_d;
      fetch_count_q  <= fetch_count_d;
    end
  end

  assign PCF         = pcf_q;
  assign InstrD      = instr_dec_q;
  assign PCD         = pc_dec_q;
  assign PCPlus4D    = pc_plus4_dec_q;
  assign ValidD      = valid_dec_q;
  assign FetchFaultD = fault_dec_q;
  assign FetchCount  = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stalls, flush, redirects,
// fault tagging at the memory boundaries, reset priority and PC wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE, InstrF;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D, FetchCount;
  logic        ValidD, FetchFaultD;

  int checks_cnt = 0;
  int fail_cnt   = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrF(InstrF),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .FetchFaultD(FetchFaultD), .FetchCount(FetchCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance one active edge, then settle so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = 32'h0;
  endtask

  task automatic check_id(input string tag, input logic [31:0] pcf, input logic [31:0] instr,
                          input logic [31:0] pcd, input logic valid, input logic fault,
                          input logic [31:0] cnt);
    check({tag, ".pcf"},   PCF, pcf);
    check({tag, ".instr"}, InstrD, instr);
    check({tag, ".pcd"},   PCD, pcd);
    check({tag, ".valid"}, {31'd0, ValidD}, {31'd0, valid});
    check({tag, ".fault"}, {31'd0, FetchFaultD}, {31'd0, fault});
    check({tag, ".cnt"},   FetchCount, cnt);
  endtask

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] I1  = 32'h00500093;
  localparam logic [31:0] I2  = 32'h00A00113;

  initial begin
    idle_inputs();
    rst = 1'b1; InstrF = I1;
    tick(); tick();
    check_id("reset", 32'hBFC00000, NOP, 32'h0, 1'b0, 1'b0, 32'd0);
    check("reset.pc4d", PCPlus4D, 32'h0);
    rst = 1'b0;

    tick();
    check_id("seq1", 32'hBFC00004, I1, 32'hBFC00000, 1'b1, 1'b0, 32'd1);
    check("seq1.pc4d", PCPlus4D, 32'hBFC00004);
    tick();
    check_id("seq2", 32'hBFC00008, I1, 32'hBFC00004, 1'b1, 1'b0, 32'd2);

    StallF = 1'b1; StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_id("stall", 32'hBFC00008, I1, 32'hBFC00004, 1'b1, 1'b0, 32'd2);
    end
    StallF = 1'b0; StallD = 1'b0;
    tick();
    check_id("resume1", 32'hBFC0000C, I1, 32'hBFC00008, 1'b1, 1'b0, 32'd3);
    tick();
    check_id("resume2", 32'hBFC00010, I1, 32'hBFC0000C, 1'b1, 1'b0, 32'd4);

    // Redirect with stall and flush: redirect beats stall, flush bubbles IF/ID.
    PCSrcE = 1'b1; PCTargetE = 32'hBFC00100; FlushD = 1'b1; StallF = 1'b1;
    tick();
    check_id("redir_flush", 32'hBFC00100, NOP, 32'hBFC00010, 1'b0, 1'b0, 32'd4);
    check("redir_flush.pc4d", PCPlus4D, 32'hBFC00014);
    idle_inputs(); InstrF = I2;
    tick();
    check_id("tgt", 32'hBFC00104, I2, 32'hBFC00100, 1'b1, 1'b0, 32'd5);

    PCSrcE = 1'b1; PCTargetE = 32'hBFC00102;
    tick();
    check_id("to_mis", 32'hBFC00102, I2, 32'hBFC00104, 1'b1, 1'b0, 32'd6);
    idle_inputs();
    tick();
    check_id("mis", 32'hBFC00106, NOP, 32'hBFC00102, 1'b1, 1'b1, 32'd7);

    PCSrcE = 1'b1; PCTargetE = 32'hBFC01000;
    tick();
    check_id("mis2", 32'hBFC01000, NOP, 32'hBFC00106, 1'b1, 1'b1, 32'd8);
    idle_inputs();
    tick();
    check_id("oor_hi", 32'hBFC01004, NOP, 32'hBFC01000, 1'b1, 1'b1, 32'd9);

    PCSrcE = 1'b1; PCTargetE = 32'hBFC00FFC;
    tick();
    check_id("oor_hi2", 32'hBFC00FFC, NOP, 32'hBFC01004, 1'b1, 1'b1, 32'd10);
    idle_inputs();
    tick();
    check_id("last_word", 32'hBFC01000, I2, 32'hBFC00FFC, 1'b1, 1'b0, 32'd11);

    // Flush beats stall on IF/ID; PC still advances.
    FlushD = 1'b1; StallD = 1'b1;
    tick();
    check_id("flush_stall", 32'hBFC01004, NOP, 32'hBFC01000, 1'b0, 1'b0, 32'd11);

    // Reset beats stall and redirect.
    StallF = 1'b1; StallD = 1'b1; FlushD = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h12345678;
    rst = 1'b1;
    tick();
    check_id("rst_prio", 32'hBFC00000, NOP, 32'h0, 1'b0, 1'b0, 32'd0);
    idle_inputs();

    PCSrcE = 1'b1; PCTargetE = 32'hFFFFFFFC;
    tick();
    check_id("to_top", 32'hFFFFFFFC, I2, 32'hBFC00000, 1'b1, 1'b0, 32'd1);
    idle_inputs();
    tick();
    check_id("top", 32'h00000000, NOP, 32'hFFFFFFFC, 1'b1, 1'b1, 32'd2);
    check("top.pc4d", PCPlus4D, 32'h0);
    tick();
    check_id("zero", 32'h00000004, NOP, 32'h00000000, 1'b1, 1'b1, 32'd3);

    // Decode stall alone: PC advances, IF/ID holds.
    StallD = 1'b1;
    tick();
    check_id("stalld", 32'h00000008, NOP, 32'h00000000, 1'b1, 1'b1, 32'd3);
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the RV32I pipeline. Owns the program counter and drives it to the instruction memory; the instruction memory returns the instruction combinationally in the same cycle.
- Selects the next PC from sequential (PC+4) or redirect (branch/jump target from EX).
- Registers the fetched word into the IF/ID pipeline register, with stall, flush and fetch-fault tagging.
- Keeps a count of instructions delivered to decode.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value after reset.
- IMEM_BASE, 32'hBFC00000, first byte address of instruction memory.
- IMEM_SIZE, 32'h00001000, instruction memory size in bytes; power of two, IMEM_BASE aligned to it.
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- StallF  input  1  hold PC (hazard unit)
- StallD  input  1  hold IF/ID register
- FlushD  input  1  replace IF/ID contents with bubble
- PCSrcE  input  1  redirect taken (branch taken or jump in EX)
- PCTargetE  input  32  redirect target
- InstrF  input  32  instruction returned by instruction memory for PCF
- PCF  output  32  current fetch address, to instruction memory
- InstrD  output  32  IF/ID instruction
- PCD  output  32  IF/ID PC
- PCPlus4D  output  32  IF/ID PC+4
- ValidD  output  1  IF/ID holds a real (non-bubble) instruction
- FetchFaultD  output  1  IF/ID instruction came from a misaligned or out-of-range PC
- FetchCount  output  32  instructions accepted into IF/ID since reset

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are clk and rst. rst is sampled on the rising clk edge only.
- Reset values:
  - PCF = RESET_VECTOR.
  - InstrD = NOP_INSTR.
  - PCD = 0, PCPlus4D = 0.
  - ValidD = 0, FetchFaultD = 0.
  - FetchCount = 0.
- rst overrides every other input in the same cycle, including mid-redirect or mid-stall.
- PCPlus4F = PCF + 4, modulo 2^32. 32'hFFFFFFFC wraps to 0. No other width extension.
- Next-PC priority (highest first):
  1. rst → RESET_VECTOR.
  2. PCSrcE → PCTargetE, loaded unmodified (no alignment masking).
  3. StallF → hold PCF.
  4. Otherwise → PCPlus4F.
- PCSrcE and StallF asserted together: redirect wins, so a taken branch is never lost.
- FaultF (combinational) = (PCF[1:0] != 0) OR (PCF < IMEM_BASE) OR (PCF > IMEM_BASE + IMEM_SIZE − 4).
- IF/ID register priority (highest first):
  1. rst → reset values.
  2. FlushD → bubble: InstrD = NOP_INSTR, ValidD = 0, FetchFaultD = 0. PCD and PCPlus4D take the current PCF and PCPlus4F (debug only).
  3. StallD → hold all IF/ID outputs.
  4. Otherwise → capture:
     - InstrD = FaultF ? NOP_INSTR : InstrF.
     - PCD = PCF, PCPlus4D = PCPlus4F.
     - ValidD = 1, FetchFaultD = FaultF.
- FlushD and StallD asserted together: flush wins.
- A faulting fetch still advances the PC normally. The fault is only tagged; downstream decides on a trap.
- FetchCount increments by 1 on exactly the cycles that take the capture branch (including faulting captures). It holds on reset-free stall or flush cycles and wraps 32'hFFFFFFFF → 0.
- Latency:
  - PCF → InstrD/PCD: 1 cycle.
  - Redirect: PCSrcE in cycle N makes PCF = PCTargetE in cycle N+1. The hazard unit asserts FlushD in cycle N to squash the wrong-path fetch.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
- Reset then 4 free-running cycles, InstrF = 32'h00500093 → PCF sequence BFC00000, BFC00004, BFC00008, BFC0000C. From the cycle after the first capture: ValidD = 1, PCD lags PCF by one cycle. FetchCount = 4 after the 4th capture.
- StallF = StallD = 1 for 3 cycles starting at PCF = BFC00008 → PCF, InstrD, PCD and FetchCount frozen. Resumes with PCF = BFC0000C after release.
- PCSrcE = 1, PCTargetE = BFC00100, FlushD = 1 in the same cycle, StallF = 1 → next cycle PCF = BFC00100, InstrD = 00000013, ValidD = 0, FetchCount unchanged.
- Redirect to BFC00102, then redirect to BFC01000 → each fetch captured with FetchFaultD = 1, InstrD = 00000013, ValidD = 1; FetchCount increments.
- rst asserted for 1 cycle mid-stall with PCSrcE = 1 → next cycle PCF = BFC00000, ValidD = 0, FetchCount = 0.
- Redirect to FFFFFFFC, no stall → following PCF = 00000000; both fetches flagged FetchFaultD = 1.
